pslip_grant_arbiter: RTL and testbench

- Grant stage of the pSLIP scheduler for one output port, directly downstream of the combinational priority selector.
- Consumes the selector's max priority and its multi-hot vector of inputs that match it. Issues one registered one-hot grant per request, chosen round-robin by a separate pointer per priority level.
- Holds the grant until the accept stage responds. Advances that level's pointer only on an accepted grant from the first iteration, per iSLIP.

---
 rtl/pslip_pkg.sv | 13 +
 rtl/pslip_rr_pick.sv | 35 +++
 rtl/pslip_grant_arbiter.sv | 109 ++++++++++
 tb/tb_pslip_grant_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pslip_pkg.sv
// Shared constants and types for the pSLIP scheduler stages.
// Default port/priority counts, derived index widths and the grant FSM state.
package pslip_pkg;
  localparam int N_DEF = 4;
  localparam int P_DEF = 4;
  localparam int IDX_W = $clog2(N_DEF);
  localparam int PRI_W = $clog2(P_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;
endpackage

// File: rtl/pslip_rr_pick.sv
// Combinational programmable-priority encoder: first set bit of req at or
// above ptr, wrapping modulo N. Shared by the grant and accept stages.
module pslip_rr_pick
  import pslip_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int IW = $clog2(N);
  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [N-1:0] win;
  logic [IW-1:0] off;
  logic [IW:0] sum;

  // Rotate the doubled vector so ptr lands at bit 0; the lowest set bit wins.
  always_comb begin
    win = N'({req, req} >> ptr);
    any = |req;
    off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (win[j]) off = IW'(j);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    idx = sum[IW-1:0];
    onehot = '0;
    if (any) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/pslip_grant_arbiter.sv
// pSLIP grant stage for one output port: registered round-robin grant with a
// pointer per priority level, held until the accept stage responds.
module pslip_grant_arbiter
  import pslip_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int P = P_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [N-1:0]         req_in,
  input  logic [$clog2(P)-1:0] pri_in,
  input  logic                 first_iter,
  output logic                 req_ready,
  output logic                 gnt_valid,
  output logic [N-1:0]         gnt_out,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic [$clog2(P)-1:0] gnt_pri,
  input  logic                 resp_valid,
  input  logic                 resp_accept
);
  localparam int IW = $clog2(N);
  localparam int PW = $clog2(P);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_e state_q, state_d;
  logic [IW-1:0] ptr_q [P];
  logic [IW-1:0] ptr_d [P];
  logic          gnt_valid_q, gnt_valid_d;
  logic [N-1:0]  gnt_out_q, gnt_out_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic [PW-1:0] gnt_pri_q, gnt_pri_d;
  logic          first_q, first_d;

  logic          xfer, resp_fire, advance;
  logic [IW-1:0] ptr_inc, pick_ptr, pick_idx;
  logic [N-1:0]  pick_oh;
  logic          pick_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < P; i++) ptr_q[i] <= '0;
      gnt_valid_q <= 1'b0;
      gnt_out_q   <= '0;
      gnt_idx_q   <= '0;
      gnt_pri_q   <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_out_q   <= gnt_out_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_pri_q   <= gnt_pri_d;
      first_q     <= first_d;
    end
  end

  // Pointer update is computed first so a same-cycle request picks from it.
  always_comb begin
    req_ready = (state_q == IDLE) | ((state_q == WAIT) & resp_valid);
    xfer      = req_valid & req_ready;
    resp_fire = (state_q == WAIT) & resp_valid;
    advance   = resp_fire & resp_accept & first_q;
    ptr_inc   = (gnt_idx_q == LAST) ? '0 : gnt_idx_q + 1'b1;
    ptr_d     = ptr_q;
    if (advance) ptr_d[gnt_pri_q] = ptr_inc;
    pick_ptr  = ptr_d[pri_in];
  end

  pslip_rr_pick #(.N(N)) u_pick (
    .req   (req_in),
    .ptr   (pick_ptr),
    .onehot(pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d = state_q;
    if (xfer) state_d = pick_any ? WAIT : IDLE;
    else if (resp_fire) state_d = IDLE;
  end

  always_comb begin
    gnt_valid_d = gnt_valid_q;
    gnt_out_d   = gnt_out_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_pri_d   = gnt_pri_q;
    first_d     = first_q;
    if (xfer && pick_any) begin
      gnt_valid_d = 1'b1;
      gnt_out_d   = pick_oh;
      gnt_idx_d   = pick_idx;
      gnt_pri_d   = pri_in;
      first_d     = first_iter;
    end else if (xfer || resp_fire) begin
      gnt_valid_d = 1'b0;
      gnt_out_d   = '0;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_out   = gnt_out_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_pri   = gnt_pri_q;
endmodule

// File: tb/tb_pslip_grant_arbiter.sv
// Self-checking bench for pslip_grant_arbiter: table-driven grant/response
// vectors plus hand sequences for back-to-back, empty requests and reset.
module tb_pslip_grant_arbiter;
  localparam int N = 4;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_in = '0;
  logic [1:0] pri_in = '0;
  logic       first_iter = 1'b0;
  logic       req_ready;
  logic       gnt_valid;
  logic [3:0] gnt_out;
  logic [1:0] gnt_idx;
  logic [1:0] gnt_pri;
  logic       resp_valid = 1'b0;
  logic       resp_accept = 1'b0;

  pslip_grant_arbiter #(.N(N), .P(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_in     (req_in),
    .pri_in     (pri_in),
    .first_iter (first_iter),
    .req_ready  (req_ready),
    .gnt_valid  (gnt_valid),
    .gnt_out    (gnt_out),
    .gnt_idx    (gnt_idx),
    .gnt_pri    (gnt_pri),
    .resp_valid (resp_valid),
    .resp_accept(resp_accept)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [1:0] pri;
    logic       first;
    logic       acc;
    logic [3:0] oh;
    logic [1:0] idx;
  } vec_t;

  typedef struct {
    logic [3:0] oh;
    logic [1:0] idx;
    logic [1:0] pri;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] r, input logic [1:0] p, input logic f,
                           input logic [3:0] oh, input logic [1:0] idx);
    req_valid  = 1'b1;
    req_in     = r;
    pri_in     = p;
    first_iter = f;
    if (r != 4'b0000) sb.push_back('{oh: oh, idx: idx, pri: p});
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    int   waited = 0;
    while (!gnt_valid && waited < 8) begin
      tick();
      waited++;
    end
    if (!gnt_valid) begin
      n_chk++;
      $display("FAIL %s_timeout: gnt_valid never rose", tag);
    end else if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL %s_sb: grant %b with no expected entry", tag, gnt_out);
    end else begin
      e = sb.pop_front();
      chk({tag, "_oh"}, 32'(gnt_out), 32'(e.oh));
      chk({tag, "_idx"}, 32'(gnt_idx), 32'(e.idx));
      chk({tag, "_pri"}, 32'(gnt_pri), 32'(e.pri));
    end
  endtask

  task automatic respond(input string tag, input logic acc);
    resp_valid  = 1'b1;
    resp_accept = acc;
    tick();
    resp_valid  = 1'b0;
    resp_accept = 1'b0;
    chk({tag, "_released"}, 32'(gnt_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // req, pri, first, accept, expected one-hot, expected index
    vecs[0]  = '{4'b1010, 2'd2, 1'b1, 1'b1, 4'b0010, 2'd1}; // ptr2 -> 2
    vecs[1]  = '{4'b1010, 2'd2, 1'b1, 1'b1, 4'b1000, 2'd3}; // ptr2 -> 0
    vecs[2]  = '{4'b1010, 2'd0, 1'b1, 1'b0, 4'b0010, 2'd1}; // reject
    vecs[3]  = '{4'b1010, 2'd0, 1'b0, 1'b1, 4'b0010, 2'd1}; // later iteration
    vecs[4]  = '{4'b1010, 2'd0, 1'b1, 1'b0, 4'b0010, 2'd1};
    vecs[5]  = '{4'b0100, 2'd1, 1'b1, 1'b1, 4'b0100, 2'd2}; // ptr1 -> 3
    vecs[6]  = '{4'b0101, 2'd1, 1'b1, 1'b1, 4'b0001, 2'd0}; // ptr1 -> 1
    vecs[7]  = '{4'b0101, 2'd1, 1'b1, 1'b0, 4'b0100, 2'd2};
    vecs[8]  = '{4'b1000, 2'd3, 1'b1, 1'b1, 4'b1000, 2'd3}; // ptr3 wraps to 0
    vecs[9]  = '{4'b1111, 2'd3, 1'b1, 1'b0, 4'b0001, 2'd0};
    vecs[10] = '{4'b1111, 2'd0, 1'b1, 1'b0, 4'b0001, 2'd0};
    vecs[11] = '{4'b1111, 2'd1, 1'b1, 1'b0, 4'b0010, 2'd1};
    vecs[12] = '{4'b1111, 2'd2, 1'b1, 1'b0, 4'b0001, 2'd0};

    #12;
    chk("rst_gnt_valid", 32'(gnt_valid), 32'd0);
    chk("rst_gnt_out", 32'(gnt_out), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      drive_req(vecs[i].req, vecs[i].pri, vecs[i].first, vecs[i].oh, vecs[i].idx);
      tick();
      req_valid = 1'b0;
      chk($sformatf("v%0d_latency", i), 32'(gnt_valid), 32'd1);
      pop_check($sformatf("v%0d", i));
      respond($sformatf("v%0d", i), vecs[i].acc);
    end

    // back-to-back response and request at the same level
    drive_req(4'b1010, 2'd2, 1'b1, 4'b0010, 2'd1);
    tick();
    req_valid = 1'b0;
    pop_check("b2b_a");
    tick();
    chk("hold_valid", 32'(gnt_valid), 32'd1);
    chk("hold_idx", 32'(gnt_idx), 32'd1);
    chk("wait_not_ready", 32'(req_ready), 32'd0);
    resp_valid  = 1'b1;
    resp_accept = 1'b1;
    drive_req(4'b1111, 2'd2, 1'b1, 4'b0100, 2'd2);
    #1;
    chk("b2b_ready", 32'(req_ready), 32'd1);
    tick();
    resp_valid  = 1'b0;
    resp_accept = 1'b0;
    req_valid   = 1'b0;
    chk("b2b_no_gap", 32'(gnt_valid), 32'd1);
    pop_check("b2b_b");
    respond("b2b_b", 1'b0);

    // empty request arriving with a response
    drive_req(4'b0100, 2'd0, 1'b1, 4'b0100, 2'd2);
    tick();
    req_valid = 1'b0;
    pop_check("emp_w");
    resp_valid = 1'b1;
    drive_req(4'b0000, 2'd3, 1'b1, 4'b0000, 2'd0);
    tick();
    resp_valid = 1'b0;
    req_valid  = 1'b0;
    chk("emp_w_valid", 32'(gnt_valid), 32'd0);
    chk("emp_w_out", 32'(gnt_out), 32'd0);
    chk("emp_w_idle_ready", 32'(req_ready), 32'd1);

    // empty request in IDLE
    drive_req(4'b0000, 2'd3, 1'b1, 4'b0000, 2'd0);
    #1;
    chk("emp_i_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("emp_i_valid", 32'(gnt_valid), 32'd0);

    // asynchronous reset while a grant is outstanding (ptr2 is 2 here)
    drive_req(4'b1111, 2'd2, 1'b1, 4'b0100, 2'd2);
    tick();
    req_valid = 1'b0;
    pop_check("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(gnt_valid), 32'd0);
    chk("mid_rst_out", 32'(gnt_out), 32'd0);
    chk("mid_rst_idx", 32'(gnt_idx), 32'd0);
    chk("mid_rst_pri", 32'(gnt_pri), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    drive_req(4'b1111, 2'd2, 1'b1, 4'b0001, 2'd0);
    tick();
    req_valid = 1'b0;
    pop_check("post_rst");
    respond("post_rst", 1'b1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
